approx_error_monitor: RTL

//  Hardware error-statistics stage placed directly downstream of Approx_adder.
//  Per sample it takes the adder's operands, its add_sub mode and its approximate result res.
//  It recomputes the exact result and measures the error distance ED = |res - exact|.

---
 rtl/approx_error_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: error-statistics stage for an approximate adder.
// Recomputes the exact sum/difference per accepted sample, measures the
// error distance |res - exact| and accumulates count, sum and max over a run.
module approx_error_monitor #(
  parameter int unsigned W     = 13,
  parameter int unsigned CNT_W = 18,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sample_valid,
  input  logic             add_sub,
  input  logic [W-1:0]     in1,
  input  logic [W-1:0]     in2,
  input  logic [W:0]       res,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] err_sum,
  output logic [W:0]       err_max,
  output logic             sum_sat
);

  localparam int unsigned RW = W + 1;   // result / ED width
  localparam int unsigned DW = W + 2;   // signed difference width

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, next_state;
  logic             start_ok_c;
  logic             accept_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] quota;

  logic             s1_vld;
  logic [RW-1:0]    res_q;
  logic [RW-1:0]    exact_q;
  logic [RW-1:0]    exact_c;

  logic signed [DW-1:0] d_c;
  logic [RW-1:0]        ed_c;
  logic [ACC_W:0]       sum_ext_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic, start acceptance and sample acceptance
  always_comb begin
    next_state = state;
    start_ok_c = 1'b0;
    accept_c   = 1'b0;
    cnt_inc_c  = sample_cnt + CNT_W'(1);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok_c = 1'b1;
          next_state = (num_samples == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (sample_valid && (sample_cnt < quota)) begin
          accept_c = 1'b1;
          if (cnt_inc_c == quota) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_vld) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == RUN) || (next_state == DRAIN);
      done <= (next_state == DONE);
    end
  end

  // Run quota and accepted-sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      quota      <= '0;
      sample_cnt <= '0;
    end else if (start_ok_c) begin
      quota      <= num_samples;
      sample_cnt <= '0;
    end else if (accept_c) begin
      sample_cnt <= cnt_inc_c;
    end
  end

  // Exact result, wrapping modulo 2^(W+1)
  always_comb begin
    exact_c = add_sub ? ({1'b0, in1} - {1'b0, in2})
                      : ({1'b0, in1} + {1'b0, in2});
  end

  // Stage 1: capture approximate and exact result of an accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      res_q   <= '0;
      exact_q <= '0;
    end else begin
      s1_vld <= accept_c;
      if (accept_c) begin
        res_q   <= res;
        exact_q <= exact_c;
      end
    end
  end

  // Error distance and widened accumulator sum
  always_comb begin
    d_c       = $signed({1'b0, res_q}) - $signed({1'b0, exact_q});
    ed_c      = RW'(d_c[DW-1] ? -d_c : d_c);
    sum_ext_c = {1'b0, err_sum} + (ACC_W+1)'(ed_c);
  end

  // Stage 2: accumulate statistics, saturating the error sum
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      err_sum   <= '0;
      err_max   <= '0;
      sum_sat   <= 1'b0;
    end else if (start_ok_c) begin
      err_count <= '0;
      err_sum   <= '0;
      err_max   <= '0;
      sum_sat   <= 1'b0;
    end else if (s1_vld) begin
      if (ed_c != '0) err_count <= err_count + CNT_W'(1);
      if (ed_c > err_max) err_max <= ed_c;
      if (sum_ext_c[ACC_W]) begin
        err_sum <= '1;
        sum_sat <= 1'b1;
      end else begin
        err_sum <= sum_ext_c[ACC_W-1:0];
      end
    end
  end

endmodule
